// File: rtl/attn_score_quantizer.sv
// Attention score quantizer: scales raw QK^T accumulator scores, rounds, saturates to INT8
// and applies an optional causal mask, tagging each score with its row/col position.
module attn_score_quantizer #(
  parameter int ACC_WIDTH   = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int SCALE_WIDTH = 16,
  parameter int MAX_SEQ_LEN = 16,
  localparam int IW = $clog2(MAX_SEQ_LEN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [IW:0]            seq_len_i,
  input  logic [SCALE_WIDTH-1:0] scale_i,
  input  logic [4:0]             shift_i,
  input  logic                   causal_mask_i,
  input  logic [ACC_WIDTH-1:0]   in_data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [DATA_WIDTH-1:0]  out_data_o,
  output logic [IW-1:0]          out_row_o,
  output logic [IW-1:0]          out_col_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   cfg_err_o,
  output logic [15:0]            sat_count_o
);
  localparam int PW = ACC_WIDTH + SCALE_WIDTH + 1;
  localparam logic signed [PW:0] QMAX = (PW+1)'((2**(DATA_WIDTH-1)) - 1);
  localparam logic signed [PW:0] QMIN = (PW+1)'(-(2**(DATA_WIDTH-1)));

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;

  logic [IW:0]            len_q, len_m1;
  logic [SCALE_WIDTH-1:0] scale_q;
  logic [4:0]             shift_q;
  logic                   causal_q;
  logic [IW-1:0]          row_q, col_q;
  logic [1:0]             vld_pipe_q;
  logic signed [PW-1:0]   s1_prod_q;
  logic [IW-1:0]          s1_row_q, s1_col_q;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic [IW-1:0]          out_row_q, out_col_q;
  logic [15:0]            sat_cnt_q;
  logic                   cfg_err_q;

  logic adv, in_fire, cfg_ok, start_ok, col_last, last_elem;
  logic signed [PW-1:0] acc_ext, scl_ext, prod_d;
  logic signed [PW:0]   wide, bias, rnd;
  logic                 sat_d, mask_d;
  logic [DATA_WIDTH-1:0] res_d;

  // One enable for the whole pipeline: everything moves only when the output slot frees up.
  assign adv       = !vld_pipe_q[1] || out_ready_i;
  assign in_fire   = in_valid_i && in_ready_o;
  assign cfg_ok    = (seq_len_i != '0) && (seq_len_i <= (IW+1)'(MAX_SEQ_LEN));
  assign start_ok  = (state_q == IDLE) && start_i && cfg_ok;
  assign len_m1    = len_q - (IW+1)'(1);
  assign col_last  = ({1'b0, col_q} == len_m1);
  assign last_elem = col_last && ({1'b0, row_q} == len_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (in_fire && last_elem) state_d = DRAIN;
      DRAIN:   if (vld_pipe_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o     = (state_q != IDLE);
    done_o     = (state_q == DONE);
    in_ready_o = (state_q == RUN) && adv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      scale_q  <= '0;
      shift_q  <= '0;
      causal_q <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
    end else if (start_ok) begin
      len_q    <= seq_len_i;
      scale_q  <= scale_i;
      shift_q  <= shift_i;
      causal_q <= causal_mask_i;
      row_q    <= '0;
      col_q    <= '0;
    end else if (in_fire) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_q + IW'(1);
      end else begin
        col_q <= col_q + IW'(1);
      end
    end
  end

  always_comb begin
    acc_ext = PW'($signed(in_data_i));
    scl_ext = PW'({1'b0, scale_q});
    prod_d  = acc_ext * scl_ext;
    // One extra bit of headroom so the rounding bias can never wrap the sum.
    wide = {s1_prod_q[PW-1], s1_prod_q};
    bias = '0;
    if (shift_q != 5'd0) bias = (PW+1)'(1) << (shift_q - 5'd1);
    rnd   = (wide + bias) >>> shift_q;
    sat_d = 1'b0;
    res_d = rnd[DATA_WIDTH-1:0];
    if (rnd > QMAX) begin
      res_d = QMAX[DATA_WIDTH-1:0];
      sat_d = 1'b1;
    end else if (rnd < QMIN) begin
      res_d = QMIN[DATA_WIDTH-1:0];
      sat_d = 1'b1;
    end
    mask_d = causal_q && (s1_col_q > s1_row_q);
    if (mask_d) res_d = QMIN[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_prod_q  <= '0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
      out_data_q <= '0;
      out_row_q  <= '0;
      out_col_q  <= '0;
    end else if (adv) begin
      vld_pipe_q <= {vld_pipe_q[0], in_fire};
      s1_prod_q  <= prod_d;
      s1_row_q   <= row_q;
      s1_col_q   <= col_q;
      out_data_q <= res_d;
      out_row_q  <= s1_row_q;
      out_col_q  <= s1_col_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= (state_q == IDLE) && start_i && !cfg_ok;
      if (start_ok)
        sat_cnt_q <= '0;
      else if (adv && vld_pipe_q[0] && sat_d && !mask_d && (sat_cnt_q != 16'hFFFF))
        sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_row_o   = out_row_q;
  assign out_col_o   = out_col_q;
  assign out_valid_o = vld_pipe_q[1];
  assign cfg_err_o   = cfg_err_q;
  assign sat_count_o = sat_cnt_q;
endmodule

// File: tb/tb_attn_score_quantizer.sv
// Self-checking bench for attn_score_quantizer: randomized tiles against a real-arithmetic model.
module tb_attn_score_quantizer;
  localparam int AW = 32, DW = 8, SW = 16, IW = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start_i = 1'b0, causal_mask_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b1;
  logic [IW:0] seq_len_i = '0;
  logic [SW-1:0] scale_i = '0;
  logic [4:0] shift_i = '0;
  logic [AW-1:0] in_data_i = '0;
  logic in_ready_o, out_valid_o, busy_o, done_o, cfg_err_o;
  logic [DW-1:0] out_data_o;
  logic [IW-1:0] out_row_o, out_col_o;
  logic [15:0] sat_count_o;

  int checks = 0, errors = 0;
  int accs[$];
  int r_data[$];
  int r_nout, r_nbad, r_done, r_lat, r_stable, r_rdy, r_stall, r_sat, r_exp_sat;
  bit r_timeout, r_busy_after;
  string r_msg;

  attn_score_quantizer dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .seq_len_i(seq_len_i), .scale_i(scale_i),
    .shift_i(shift_i), .causal_mask_i(causal_mask_i), .in_data_i(in_data_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .out_data_o(out_data_o),
    .out_row_o(out_row_o), .out_col_o(out_col_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .busy_o(busy_o), .done_o(done_o), .cfg_err_o(cfg_err_o),
    .sat_count_o(sat_count_o)
  );

  always #5 clk = ~clk;

  // Reference: exact real-valued scale, round half up, clamp to INT8, mask upper triangle.
  function automatic int model(longint acc, longint sc, int sh, bit masked, output bit sat);
    real v;
    longint r;
    sat = 1'b0;
    if (masked) return -128;
    v = $floor(real'(acc * sc) / real'(64'sd1 << sh) + 0.5);
    r = longint'(v);
    if (r > 127) begin sat = 1'b1; return 127; end
    if (r < -128) begin sat = 1'b1; return -128; end
    return int'(r);
  endfunction

  // bp: 0 = always ready/valid, 1 = random valid/ready, 2 = ready low for cycles 4..8.
  task automatic run_tile(input int len, input int sc, input int sh, input bit cm,
                          input int bp, input bit poke);
    int n, in_idx, cyc, first_in, first_out;
    int ed[$], er[$], ec[$];
    bit sat, finished, held;
    logic [DW-1:0] hd;
    logic [IW-1:0] hr, hc;
    n = len * len;
    r_nout = 0; r_nbad = 0; r_done = 0; r_stable = 0; r_rdy = 0; r_stall = 0; r_exp_sat = 0;
    r_msg = ""; r_data.delete();
    for (int i = 0; i < n; i++) begin
      ed.push_back(model(accs[i], sc, sh, cm && ((i % len) > (i / len)), sat));
      er.push_back(i / len);
      ec.push_back(i % len);
      if (sat) r_exp_sat++;
    end
    start_i = 1'b1; seq_len_i = (IW+1)'(len); scale_i = SW'(sc); shift_i = 5'(sh);
    causal_mask_i = cm;
    @(negedge clk);
    start_i = 1'b0;
    in_idx = 0; cyc = 0; first_in = -1; first_out = -1; finished = 0; held = 0;
    hd = '0; hr = '0; hc = '0;
    while (!finished && cyc < 2000) begin
      in_valid_i = (in_idx < n) && (bp != 1 || $urandom_range(3) != 0);
      in_data_i  = (in_idx < n) ? accs[in_idx] : 0;
      case (bp)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = ($urandom_range(2) != 0);
        default: out_ready_i = !(cyc >= 4 && cyc < 9);
      endcase
      if (poke && cyc == 2) begin
        start_i = 1'b1; seq_len_i = 1; scale_i = '0; shift_i = 5'd3; causal_mask_i = !cm;
      end else start_i = 1'b0;
      #1;
      if (held && (!out_valid_o || out_data_o !== hd || out_row_o !== hr || out_col_o !== hc))
        r_stable++;
      if (out_valid_o && !out_ready_i) begin
        r_stall++;
        if (in_ready_o) r_rdy++;
      end
      if (done_o) begin r_done++; finished = 1; end
      if (in_valid_i && in_ready_o) begin
        if (first_in < 0) first_in = cyc;
        in_idx++;
      end
      if (out_valid_o && first_out < 0) first_out = cyc;
      if (out_valid_o && out_ready_i) begin
        if (r_nout >= n || $signed(out_data_o) != ed[r_nout] || int'(out_row_o) != er[r_nout]
            || int'(out_col_o) != ec[r_nout]) begin
          r_nbad++;
          if (r_msg == "")
            r_msg = $sformatf("elem %0d got %0d@(%0d,%0d) want %0d@(%0d,%0d)", r_nout,
                              $signed(out_data_o), out_row_o, out_col_o,
                              (r_nout < n) ? ed[r_nout] : 0, (r_nout < n) ? er[r_nout] : 0,
                              (r_nout < n) ? ec[r_nout] : 0);
        end
        r_data.push_back(int'($signed(out_data_o)));
        r_nout++;
      end
      held = out_valid_o && !out_ready_i;
      hd = out_data_o; hr = out_row_o; hc = out_col_o;
      @(negedge clk);
      cyc++;
    end
    r_timeout = !finished;
    start_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    #1;
    r_done += int'(done_o);
    r_busy_after = busy_o;
    r_sat = int'(sat_count_o);
    r_lat = first_out - first_in;
  endtask

  task automatic test_reset;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (done_o !== 1'b0 || cfg_err_o !== 1'b0) begin errors++; $display("FAIL reset_pulses: got done=%b cfg_err=%b want 0/0", done_o, cfg_err_o); end
    checks++; if (out_data_o !== '0 || out_row_o !== '0 || out_col_o !== '0) begin errors++; $display("FAIL reset_out_regs: got %h/%h/%h want 0", out_data_o, out_row_o, out_col_o); end
    checks++; if (sat_count_o !== 16'd0) begin errors++; $display("FAIL reset_sat_count: got %0d want 0", sat_count_o); end
  endtask

  task automatic test_passthrough;
    accs = '{5, -3, 127, -128};
    run_tile(2, 1, 0, 1'b0, 0, 1'b0);
    checks++; if (r_timeout || r_nout != 4 || r_nbad != 0) begin errors++; $display("FAIL pass_stream: got %0d outputs %0d bad timeout=%b want 4/0/0 %s", r_nout, r_nbad, r_timeout, r_msg); end
    checks++; if (r_data.size() != 4 || r_data[0] != 5 || r_data[1] != -3 || r_data[2] != 127 || r_data[3] != -128) begin errors++; $display("FAIL pass_values: got %p want 5,-3,127,-128", r_data); end
    checks++; if (r_lat != 2) begin errors++; $display("FAIL pass_latency: got %0d want 2", r_lat); end
    checks++; if (r_done != 1) begin errors++; $display("FAIL pass_done_count: got %0d want 1", r_done); end
    checks++; if (r_busy_after !== 1'b0) begin errors++; $display("FAIL pass_busy_after: got %b want 0", r_busy_after); end
  endtask

  task automatic test_rounding;
    accs = '{100, -100, 0, 128};
    run_tile(2, 181, 8, 1'b0, 0, 1'b0);
    checks++; if (r_timeout || r_nout != 4 || r_nbad != 0) begin errors++; $display("FAIL round_stream: got %0d outputs %0d bad want 4/0 %s", r_nout, r_nbad, r_msg); end
    checks++; if (r_data.size() != 4 || r_data[0] != 71 || r_data[1] != -71 || r_data[2] != 0 || r_data[3] != 91) begin errors++; $display("FAIL round_values: got %p want 71,-71,0,91", r_data); end
    checks++; if (r_sat != 0) begin errors++; $display("FAIL round_sat: got %0d want 0", r_sat); end
  endtask

  task automatic test_saturation;
    accs = '{300};
    run_tile(1, 1, 0, 1'b0, 0, 1'b0);
    checks++; if (r_data.size() != 1 || r_data[0] != 127 || r_sat != 1) begin errors++; $display("FAIL sat_pos: got %p sat=%0d want 127 sat=1", r_data, r_sat); end
    accs = '{-1000};
    run_tile(1, 1, 0, 1'b0, 0, 1'b0);
    checks++; if (r_data.size() != 1 || r_data[0] != -128 || r_sat != 1) begin errors++; $display("FAIL sat_neg: got %p sat=%0d want -128 sat=1", r_data, r_sat); end
    accs = '{300, -1000, 0, 0};
    run_tile(2, 1, 0, 1'b0, 0, 1'b0);
    checks++; if (r_nbad != 0 || r_nout != 4 || r_sat != 2) begin errors++; $display("FAIL sat_tile: got bad=%0d n=%0d sat=%0d want 0/4/2 %s", r_nbad, r_nout, r_sat, r_msg); end
  endtask

  task automatic test_causal;
    int want[9] = '{10, -128, -128, 10, 10, -128, 10, 10, 10};
    int nbad_v = 0;
    accs.delete();
    for (int i = 0; i < 9; i++) accs.push_back(10);
    run_tile(3, 1, 0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 9; i++) if (i >= r_data.size() || r_data[i] != want[i]) nbad_v++;
    checks++; if (nbad_v != 0 || r_nbad != 0) begin errors++; $display("FAIL causal_values: got %p want %p", r_data, want); end
    checks++; if (r_sat != 0) begin errors++; $display("FAIL causal_sat: got %0d want 0", r_sat); end
  endtask

  task automatic test_backpressure;
    accs.delete();
    for (int i = 0; i < 9; i++) accs.push_back(int'($urandom_range(200)) - 100);
    run_tile(3, 3, 1, 1'b0, 2, 1'b0);
    checks++; if (r_timeout || r_nout != 9 || r_nbad != 0) begin errors++; $display("FAIL bp_stream: got %0d outputs %0d bad want 9/0 %s", r_nout, r_nbad, r_msg); end
    checks++; if (r_stall != 5 || r_stable != 0) begin errors++; $display("FAIL bp_hold: got stall=%0d unstable=%0d want 5/0", r_stall, r_stable); end
    checks++; if (r_rdy != 0) begin errors++; $display("FAIL bp_in_ready: got %0d ready-while-stalled cycles want 0", r_rdy); end
  endtask

  task automatic test_random;
    for (int t = 0; t < 8; t++) begin
      int len, sc, sh;
      bit cm, wide_acc;
      len = int'($urandom_range(16, 1)); sc = int'($urandom_range(65535));
      sh = int'($urandom_range(31)); cm = 1'($urandom_range(1)); wide_acc = 1'($urandom_range(1));
      accs.delete();
      for (int i = 0; i < len * len; i++)
        accs.push_back(wide_acc ? int'($urandom) : int'($urandom_range(4000)) - 2000);
      run_tile(len, sc, sh, cm, 1, 1'b0);
      checks++; if (r_timeout || r_nout != len * len || r_nbad != 0 || r_stable != 0) begin errors++; $display("FAIL rand_tile%0d: got n=%0d bad=%0d unstable=%0d want %0d/0/0 %s", t, r_nout, r_nbad, r_stable, len * len, r_msg); end
      checks++; if (r_sat != r_exp_sat || r_done != 1) begin errors++; $display("FAIL rand_sat%0d: got sat=%0d done=%0d want %0d/1", t, r_sat, r_done, r_exp_sat); end
    end
  endtask

  task automatic test_errors;
    @(negedge clk);
    seq_len_i = 0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    checks++; if (cfg_err_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL cfg_err_zero: got err=%b busy=%b want 1/0", cfg_err_o, busy_o); end
    @(negedge clk);
    checks++; if (cfg_err_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL cfg_err_pulse: got err=%b busy=%b want 0/0", cfg_err_o, busy_o); end
    seq_len_i = 17; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    checks++; if (cfg_err_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL cfg_err_big: got err=%b busy=%b want 1/0", cfg_err_o, busy_o); end
    @(negedge clk);
    accs.delete();
    for (int i = 0; i < 9; i++) accs.push_back(int'($urandom_range(100)) - 50);
    run_tile(3, 2, 1, 1'b0, 1, 1'b1);
    checks++; if (r_timeout || r_nout != 9 || r_nbad != 0 || r_done != 1) begin errors++; $display("FAIL start_while_busy: got n=%0d bad=%0d done=%0d want 9/0/1 %s", r_nout, r_nbad, r_done, r_msg); end
  endtask

  task automatic test_reset_mid;
    start_i = 1'b1; seq_len_i = 4; scale_i = 1; shift_i = 0; causal_mask_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0; in_valid_i = 1'b1; in_data_i = 400; out_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    in_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL reset_mid: got valid=%b ready=%b busy=%b want 0/0/0", out_valid_o, in_ready_o, busy_o); end
    checks++; if (sat_count_o !== 16'd0) begin errors++; $display("FAIL reset_mid_sat: got %0d want 0", sat_count_o); end
    @(negedge clk);
    rst_n = 1'b1; out_ready_i = 1'b1;
    @(negedge clk);
    accs = '{7, -9, 33, -44};
    run_tile(2, 1, 0, 1'b0, 0, 1'b0);
    checks++; if (r_timeout || r_nout != 4 || r_nbad != 0 || r_done != 1) begin errors++; $display("FAIL after_reset_tile: got n=%0d bad=%0d done=%0d want 4/0/1 %s", r_nout, r_nbad, r_done, r_msg); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_passthrough;
    test_rounding;
    test_saturation;
    test_causal;
    test_backpressure;
    test_random;
    test_errors;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
